// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM control unit for the accumulator CPU
module multicycle_control_fsm #(
   parameter int OPW     = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPW-1:0]   opcode,
   input  logic             acc_zero,
   input  logic             mem_ready,
   output logic             incpc,
   output logic             ldpc,
   output logic             ldir,
   output logic             ldacc,
   output logic             clracc,
   output logic             rd,
   output logic             wr,
   output logic             y,
   output logic             illegal,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
   } state_t;

   // Wait counter only needs to reach TIMEOUT-1.
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
   localparam bit TO_EN = (TIMEOUT != 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             terr_q, terr_d;
   logic [WCW-1:0]   wait_q, wait_d;

   logic       upper_set;
   logic [3:0] op_lo;
   logic       is_lda, is_sta, is_clr, is_jmp, is_jz, is_nop, is_hlt, legal;
   logic       wait_expire;

   // Any set bit above the low nibble makes the opcode illegal.
   generate
      if (OPW > 4) begin : g_upper
         assign upper_set = |opcode[OPW-1:4];
      end else begin : g_no_upper
         assign upper_set = 1'b0;
      end
   endgenerate

   assign op_lo  = opcode[3:0];
   assign is_lda = !upper_set && (op_lo == 4'b0001);
   assign is_sta = !upper_set && (op_lo == 4'b1110);
   assign is_clr = !upper_set && (op_lo == 4'b0100);
   assign is_jmp = !upper_set && (op_lo == 4'b1000);
   assign is_jz  = !upper_set && (op_lo == 4'b1001);
   assign is_nop = !upper_set && (op_lo == 4'b1011);
   assign is_hlt = !upper_set && (op_lo == 4'b1111);
   assign legal  = is_lda | is_sta | is_clr | is_jmp | is_jz | is_nop | is_hlt;

   // A wait cycle that would be the TIMEOUT-th in a row; mem_ready wins.
   assign wait_expire = TO_EN && (wait_q == WAIT_LAST) && !mem_ready;

   assign timeout_err = terr_q;
   assign instr_count = count_q;

   // Next-state, counters and combinational control outputs.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      terr_d  = terr_q;
      wait_d  = '0;
      incpc   = 1'b0;
      ldpc    = 1'b0;
      ldir    = 1'b0;
      ldacc   = 1'b0;
      clracc  = 1'b0;
      rd      = 1'b0;
      wr      = 1'b0;
      y       = 1'b0;
      illegal = 1'b0;
      halted  = 1'b0;
      case (state_q)
         S_INIT: begin
            clracc  = 1'b1;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            rd = 1'b1;
            if (mem_ready) begin
               ldir    = 1'b1;
               incpc   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_expire) begin
               state_d = S_HALT;
               terr_d  = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            illegal = !legal;
            if (is_lda || is_sta) begin
               state_d = S_MEM;
            end else if (is_hlt) begin
               state_d = S_HALT;
               count_d = count_q + 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            clracc  = is_clr;
            ldpc    = is_jmp | (is_jz & acc_zero);
            state_d = S_FETCH;
            count_d = count_q + 1'b1;
         end
         S_MEM: begin
            if (is_sta) begin
               wr = 1'b1;
               y  = 1'b1;
            end else begin
               rd    = 1'b1;
               ldacc = mem_ready;
            end
            if (mem_ready) begin
               state_d = S_FETCH;
               count_d = count_q + 1'b1;
            end else if (wait_expire) begin
               state_d = S_HALT;
               terr_d  = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // State, retire counter, sticky error and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         count_q <= '0;
         terr_q  <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         terr_q  <= terr_d;
         wait_q  <= wait_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized instruction-level bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

   localparam int OPW     = 5;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 2;

   // Control vector bit positions: {incpc,ldpc,ldir,ldacc,clracc,rd,wr,y,illegal,halted}
   localparam logic [9:0] C_INCPC  = 10'b1000000000;
   localparam logic [9:0] C_LDPC   = 10'b0100000000;
   localparam logic [9:0] C_LDIR   = 10'b0010000000;
   localparam logic [9:0] C_LDACC  = 10'b0001000000;
   localparam logic [9:0] C_CLRACC = 10'b0000100000;
   localparam logic [9:0] C_RD     = 10'b0000010000;
   localparam logic [9:0] C_WR     = 10'b0000001000;
   localparam logic [9:0] C_Y      = 10'b0000000100;
   localparam logic [9:0] C_ILL    = 10'b0000000010;
   localparam logic [9:0] C_HALTED = 10'b0000000001;

   logic             clk = 1'b0;
   logic             rst;
   logic [OPW-1:0]   opcode;
   logic             acc_zero;
   logic             mem_ready;
   logic             incpc, ldpc, ldir, ldacc, clracc, rd, wr, y, illegal, halted;
   logic             timeout_err;
   logic [CNT_W-1:0] instr_count;
   logic [9:0]       ctl_w;

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;
   int exp_terr = 0;

   multicycle_control_fsm #(.OPW(OPW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .acc_zero(acc_zero), .mem_ready(mem_ready),
      .incpc(incpc), .ldpc(ldpc), .ldir(ldir), .ldacc(ldacc), .clracc(clracc),
      .rd(rd), .wr(wr), .y(y), .illegal(illegal), .halted(halted),
      .timeout_err(timeout_err), .instr_count(instr_count)
   );

   assign ctl_w = {incpc, ldpc, ldir, ldacc, clracc, rd, wr, y, illegal, halted};

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, check settled outputs 1ns later.
   task automatic step(input logic r, input logic mr, input logic [OPW-1:0] op,
                       input logic az, input logic [9:0] exp_ctl, input string tag);
      @(negedge clk);
      rst = r; mem_ready = mr; opcode = op; acc_zero = az;
      #1;
      check_val({tag, ".ctl"}, 32'(ctl_w), 32'(exp_ctl));
      check_val({tag, ".cnt"}, 32'(instr_count), 32'(exp_cnt));
      check_val({tag, ".terr"}, 32'(timeout_err), 32'(exp_terr));
   endtask

   // First cycle after reset is released: INIT drives only clracc.
   task automatic init_check();
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'(($urandom)); opcode = OPW'($urandom);
      #1;
      exp_cnt = 0; exp_terr = 0;
      check_val("init.ctl", 32'(ctl_w), 32'(C_CLRACC));
      check_val("init.cnt", 32'(instr_count), 32'(0));
      check_val("init.terr", 32'(timeout_err), 32'(0));
   endtask

   task automatic retire();
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
   endtask

   function automatic int draw_waits();
      if ($urandom_range(0, 9) < 7) return $urandom_range(0, 2);
      return $urandom_range(3, 6);
   endfunction

   // A memory-handshake phase: `waits` low cycles then a ready cycle, cut short by timeout.
   task automatic access(input logic [9:0] base, input logic [9:0] done, input logic [OPW-1:0] op,
                         input int waits, input string tag, output bit timed_out);
      timed_out = 1'b0;
      for (int k = 0; k <= waits; k++) begin
         if (k == waits) begin
            step(1'b0, 1'b1, op, 1'(($urandom)), done, tag);
         end else begin
            step(1'b0, 1'b0, op, 1'(($urandom)), base, tag);
            if (k == TIMEOUT - 1) begin
               timed_out = 1'b1;
               exp_terr  = 1;
               break;
            end
         end
      end
   endtask

   // Runs one instruction through the model; returns 1 if the FSM ends in HALT.
   task automatic run_instr(input logic [OPW-1:0] op, output bit stopped);
      bit         to;
      bit         legal;
      logic [3:0] lo;
      logic       az;
      logic [9:0] e;
      lo    = op[3:0];
      legal = (op[OPW-1:4] == '0) &&
              (lo == 4'd1 || lo == 4'd14 || lo == 4'd4 || lo == 4'd8 ||
               lo == 4'd9 || lo == 4'd11 || lo == 4'd15);
      stopped = 1'b0;
      access(C_RD, C_RD | C_LDIR | C_INCPC, OPW'($urandom), draw_waits(), "fetch", to);
      if (to) begin
         stopped = 1'b1;
         return;
      end
      step(1'b0, 1'(($urandom)), op, 1'(($urandom)), legal ? 10'd0 : C_ILL, "decode");
      if (legal && lo == 4'd15) begin
         retire();
         stopped = 1'b1;
      end else if (legal && (lo == 4'd1 || lo == 4'd14)) begin
         if (lo == 4'd1) access(C_RD, C_RD | C_LDACC, op, draw_waits(), "mem_lda", to);
         else            access(C_WR | C_Y, C_WR | C_Y, op, draw_waits(), "mem_sta", to);
         if (to) stopped = 1'b1;
         else    retire();
      end else begin
         az = 1'(($urandom));
         e  = 10'd0;
         if (legal && lo == 4'd4) e = C_CLRACC;
         if (legal && (lo == 4'd8 || (lo == 4'd9 && az))) e = C_LDPC;
         step(1'b0, 1'(($urandom)), op, az, e, "exec");
         retire();
      end
   endtask

   function automatic logic [OPW-1:0] draw_op();
      logic [3:0] legal_lo [7] = '{4'd1, 4'd14, 4'd4, 4'd8, 4'd9, 4'd11, 4'd15};
      if ($urandom_range(0, 9) < 7) return OPW'(legal_lo[$urandom_range(0, 6)]);
      return OPW'($urandom);
   endfunction

   initial begin
      bit stopped;
      rst = 1'b1; mem_ready = 1'b0; opcode = '0; acc_zero = 1'b0;
      repeat (2) @(posedge clk);
      init_check();

      for (int n = 0; n < 300; n++) begin
         run_instr(draw_op(), stopped);
         if (stopped) begin
            repeat (2) step(1'b0, 1'(($urandom)), OPW'($urandom), 1'(($urandom)), C_HALTED, "halt");
            step(1'b1, 1'(($urandom)), OPW'($urandom), 1'(($urandom)), C_HALTED, "halt_rst");
            init_check();
         end
      end

      // Reset in the middle of a stalled store: wr stays up this cycle, gone after the edge.
      access(C_RD, C_RD | C_LDIR | C_INCPC, OPW'($urandom), 0, "d_fetch", stopped);
      step(1'b0, 1'b1, OPW'(14), 1'b0, 10'd0, "d_decode");
      step(1'b0, 1'b0, OPW'(14), 1'b0, C_WR | C_Y, "d_mem");
      step(1'b1, 1'b0, OPW'(14), 1'b0, C_WR | C_Y, "d_mem_rst");
      init_check();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised multi-cycle control unit for the accumulator CPU. It replaces the single-cycle opcode decoder with a FETCH/DECODE/EXECUTE state machine that handshakes with memory through mem_ready and has a wait-state timeout. It also adds a halt state, conditional branching and a retired-instruction counter. It sits between the instruction register, the memory interface and the PC/ACC datapath.

Parameters:
OPW, 4, opcode width (>=4); the low 4 bits select the operation and any set upper bit makes the opcode illegal.
TIMEOUT, 16, consecutive mem_ready-low cycles before timeout; 0 disables the timeout.
CNT_W, 16, width of instr_count.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
opcode  in  OPW  instruction-register opcode field; valid from DECODE onwards.
acc_zero  in  1  accumulator == 0 flag.
mem_ready  in  1  memory completes the current rd/wr access this cycle.
incpc  out  1  PC <= PC+1.
ldpc  out  1  PC <= operand address.
ldir  out  1  IR <= memory data.
ldacc  out  1  ACC <= memory data.
clracc  out  1  ACC <= 0.
rd  out  1  memory read request.
wr  out  1  memory write request.
y  out  1  data-bus mux select: 1 = ACC drives the bus, 0 = memory.
illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
halted  out  1  FSM is in HALT.
timeout_err  out  1  sticky; set when a memory wait times out.
instr_count  out  CNT_W  retired-instruction counter.

Behaviour:
- States: INIT, FETCH, DECODE, EXEC, MEM, HALT. State, instr_count and timeout_err are registered. Control outputs are combinational from state, opcode, acc_zero and mem_ready.
- Reset: state <= INIT, instr_count <= 0, timeout_err <= 0, wait counter <= 0. While in INIT all outputs are 0 except clracc=1. INIT always goes to FETCH next cycle.
- FETCH: rd=1.
  - When mem_ready=1: ldir=1 and incpc=1 that cycle, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE: all control outputs 0.
  - illegal=1 if opcode is undefined.
  - Next state MEM for LDA/STA, HALT for HLT, EXEC for everything else.
- Opcode map (low 4 bits):
  - 0001 LDA
  - 1110 STA
  - 0100 CLR
  - 1000 JMP
  - 1001 JZ
  - 1011 NOP
  - 1111 HLT
  - All others are illegal and execute as NOP.
- EXEC (one cycle), then FETCH:
  - CLR: clracc=1.
  - JMP: ldpc=1.
  - JZ: ldpc=acc_zero.
  - NOP and illegal: no control output.
- MEM:
  - LDA: rd=1, y=0; ldacc=1 in the cycle mem_ready=1.
  - STA: wr=1, y=1, rd=0.
  - rd/wr are held until mem_ready=1, then next state FETCH.
- Retire: instr_count increments by 1 on the cycle the FSM leaves EXEC or MEM for FETCH; it wraps at 2^CNT_W.
- HLT: instr_count increments on the DECODE->HALT transition.
- Timeout:
  - The wait counter counts consecutive FETCH/MEM cycles with mem_ready=0 and clears on mem_ready=1 or on a state change.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 while mem_ready=0, next state HALT and timeout_err <= 1.
  - If mem_ready=1 in that same cycle, mem_ready wins and there is no timeout.
- HALT: all control outputs 0, halted=1. Only rst exits HALT.
- Reset mid-access: rd/wr deassert at the first edge with rst=1. rst overrides every transition and counter update.
- Minimum latency with mem_ready held high:
  - NOP/CLR/JMP/JZ: 3 cycles (FETCH, DECODE, EXEC).
  - LDA/STA: 3 cycles (FETCH, DECODE, MEM).

Test Plan:
- Reset, then mem_ready=1 and opcode=1011 -> 1 cycle clracc=1 (INIT); FETCH rd=1, incpc=1, ldir=1; DECODE and EXEC all outputs 0; instr_count=1 after 4 cycles.
- opcode=1110, mem_ready low for 3 cycles in MEM then high -> wr=1, y=1, rd=0 for 4 cycles; FSM returns to FETCH; instr_count increments by 1.
- opcode=0001 with mem_ready=1 -> in MEM: rd=1, ldacc=1, y=0 for 1 cycle. opcode=1001: acc_zero=1 gives ldpc=1 in EXEC; acc_zero=0 gives ldpc=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after the 4th wait cycle; timeout_err=1 and halted=1 until rst. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no error.
- opcode=0011 -> illegal=1 for exactly the DECODE cycle; executes as NOP. opcode=1111 -> halted=1 and held; rst mid-MEM drops wr next edge and resumes at INIT.
- CNT_W=2: run 5 NOPs -> instr_count sequence 1,2,3,0,1.
